// File: rtl/shadow_stack_ctrl.sv
// Shadow-stack RAM sequencer: pushes return addresses on call events, pops and
// compares them on return events, and flags mismatch/overflow/underflow violations.
module shadow_stack_ctrl #(
    parameter int unsigned DEPTH_LOG2     = 6,
    parameter bit          UNDERFLOW_VIOL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid,
    input  logic [31:0]           push_addr,
    output logic                  push_ready,
    input  logic                  pop_valid,
    input  logic [31:0]           pop_target,
    output logic                  pop_ready,
    input  logic                  irq_ack,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [DEPTH_LOG2:0]   depth,
    output logic                  stack_violation,
    output logic                  interrupt,
    output logic                  overflow,
    output logic                  underflow,
    output logic [2:0]            fsm_state
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH_W = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(1 << DEPTH_LOG2);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH    = 3'd1,
        ST_POP_RD  = 3'd2,
        ST_POP_CMP = 3'd3,
        ST_VIOL    = 3'd4
    } state_e;

    state_e                state_q,    state_d;
    logic [DEPTH_LOG2-1:0] sp_q,       sp_d;
    logic [DEPTH_W-1:0]    depth_q,    depth_d;
    logic [DATA_W-1:0]     addr_q,     addr_d;
    logic [DATA_W-1:0]     tgt_q,      tgt_d;
    logic [DEPTH_LOG2-1:0] mem_addr_q, mem_addr_d;
    logic                  viol_q,     viol_d;
    logic                  ovf_q,      ovf_d;
    logic                  unf_q,      unf_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sp_q       <= '0;
            depth_q    <= '0;
            addr_q     <= '0;
            tgt_q      <= '0;
            mem_addr_q <= '0;
            viol_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            depth_q    <= depth_d;
            addr_q     <= addr_d;
            tgt_q      <= tgt_d;
            mem_addr_q <= mem_addr_d;
            viol_q     <= viol_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Next-state logic; RAM address is computed at accept so the RAM sees only registers
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        depth_d    = depth_q;
        addr_d     = addr_q;
        tgt_d      = tgt_q;
        mem_addr_d = mem_addr_q;
        viol_d     = viol_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        case (state_q)
            ST_IDLE: begin
                if (pop_valid) begin
                    if (depth_q == '0) begin
                        if (UNDERFLOW_VIOL) begin
                            unf_d   = 1'b1;
                            state_d = ST_VIOL;
                        end
                    end else begin
                        tgt_d      = pop_target;
                        mem_addr_d = sp_q - 1'b1;
                        state_d    = ST_POP_RD;
                    end
                end else if (push_valid) begin
                    if (depth_q == DEPTH_FULL) begin
                        ovf_d   = 1'b1;
                        state_d = ST_VIOL;
                    end else begin
                        addr_d     = push_addr;
                        mem_addr_d = sp_q;
                        state_d    = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                sp_d    = sp_q + 1'b1;
                depth_d = depth_q + 1'b1;
                state_d = ST_IDLE;
            end
            ST_POP_RD: begin
                sp_d    = sp_q - 1'b1;
                depth_d = depth_q - 1'b1;
                state_d = ST_POP_CMP;
            end
            ST_POP_CMP: begin
                state_d = (mem_rdata == tgt_q) ? ST_IDLE : ST_VIOL;
            end
            ST_VIOL: begin
                if (irq_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_VIOL) begin
            viol_d = 1'b1;
        end
    end

    assign pop_ready       = (state_q == ST_IDLE);
    assign push_ready      = (state_q == ST_IDLE) && !pop_valid;
    assign mem_we          = (state_q == ST_PUSH);
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = addr_q;
    assign depth           = depth_q;
    assign stack_violation = viol_q;
    assign interrupt       = (state_q == ST_VIOL);
    assign overflow        = ovf_q;
    assign underflow       = unf_q;
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Directed bench for shadow_stack_ctrl: a 4-entry stack with underflow checking,
// plus a second instance with underflow checking disabled.
module tb_shadow_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Instance A: DEPTH_LOG2=2, UNDERFLOW_VIOL=1
    logic        push_valid, pop_valid, irq_ack;
    logic [31:0] push_addr, pop_target;
    logic        push_ready, pop_ready, mem_we;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  depth, fsm_state;
    logic        stack_violation, interrupt, overflow, underflow;

    // Instance B: DEPTH_LOG2=2, UNDERFLOW_VIOL=0
    logic        b_push_valid, b_pop_valid, b_irq_ack;
    logic [31:0] b_push_addr, b_pop_target;
    logic        b_push_ready, b_pop_ready, b_mem_we;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;
    logic [2:0]  b_depth, b_fsm_state;
    logic        b_stack_violation, b_interrupt, b_overflow, b_underflow;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int wr_snap;
    logic [31:0] ram [4];

    shadow_stack_ctrl #(.DEPTH_LOG2(2), .UNDERFLOW_VIOL(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_addr(push_addr), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_target(pop_target), .pop_ready(pop_ready),
        .irq_ack(irq_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .depth(depth), .stack_violation(stack_violation), .interrupt(interrupt),
        .overflow(overflow), .underflow(underflow), .fsm_state(fsm_state)
    );

    shadow_stack_ctrl #(.DEPTH_LOG2(2), .UNDERFLOW_VIOL(1'b0)) u_dut_nu (
        .clk(clk), .reset(reset),
        .push_valid(b_push_valid), .push_addr(b_push_addr), .push_ready(b_push_ready),
        .pop_valid(b_pop_valid), .pop_target(b_pop_target), .pop_ready(b_pop_ready),
        .irq_ack(b_irq_ack),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .depth(b_depth), .stack_violation(b_stack_violation), .interrupt(b_interrupt),
        .overflow(b_overflow), .underflow(b_underflow), .fsm_state(b_fsm_state)
    );

    // Single-port synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller one cycle after the accept edge (PUSH state)
    task automatic push_op(input logic [31:0] a);
        push_valid = 1'b1;
        push_addr  = a;
        tick();
        push_valid = 1'b0;
    endtask

    // Leaves the caller one cycle after the accept edge (POP_RD state)
    task automatic pop_op(input logic [31:0] t);
        pop_valid  = 1'b1;
        pop_target = t;
        tick();
        pop_valid  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ram[i] = 32'h0;
        reset = 1'b0;
        push_valid = 1'b0; pop_valid = 1'b0; irq_ack = 1'b0;
        push_addr = '0; pop_target = '0;
        b_push_valid = 1'b0; b_pop_valid = 1'b0; b_irq_ack = 1'b0;
        b_push_addr = '0; b_pop_target = '0; b_mem_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", fsm_state, 0);
        check("rst_depth", depth, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_viol", stack_violation, 0);
        check("rst_irq", interrupt, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_push_rdy", push_ready, 1);
        check("rst_pop_rdy", pop_ready, 1);
        reset = 1'b1;

        // Matching push/pop
        push_op(32'h0000_1008);
        check("t1_we", mem_we, 1);
        check("t1_addr", mem_addr, 0);
        check("t1_wdata", mem_wdata, 32'h0000_1008);
        check("t1_push_rdy_busy", push_ready, 0);
        tick();
        check("t1_depth1", depth, 1);
        pop_op(32'h0000_1008);
        check("t1_poprd_state", fsm_state, 2);
        check("t1_poprd_addr", mem_addr, 0);
        check("t1_poprd_we", mem_we, 0);
        check("t1_pop_rdy_busy", pop_ready, 0);
        tick();
        check("t1_cmp_state", fsm_state, 3);
        check("t1_depth0", depth, 0);
        tick();
        check("t1_idle", fsm_state, 0);
        check("t1_pop_rdy", pop_ready, 1);
        check("t1_noviol", stack_violation, 0);

        // Mismatching return target
        push_op(32'h0000_2000);
        tick();
        pop_op(32'h0000_2004);
        tick();
        tick();
        check("t2_viol_state", fsm_state, 4);
        check("t2_irq", interrupt, 1);
        check("t2_depth", depth, 0);
        push_valid = 1'b1;
        push_addr  = 32'h0000_DEAD;
        tick();
        check("t2_hold_state", fsm_state, 4);
        check("t2_sticky", stack_violation, 1);
        check("t2_irq_hold", interrupt, 1);
        check("t2_push_rdy", push_ready, 0);
        check("t2_pop_rdy", pop_ready, 0);
        check("t2_no_we", mem_we, 0);
        push_valid = 1'b0;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t2_ack_state", fsm_state, 0);
        check("t2_ack_irq", interrupt, 0);
        check("t2_ack_sticky", stack_violation, 1);

        // Fill to capacity, then overflow
        for (int i = 0; i < 4; i++) begin
            push_op(32'h0000_3000 + 32'(4 * i));
            tick();
        end
        check("t3_full", depth, 4);
        wr_snap = wr_cnt;
        push_op(32'h0000_3010);
        check("t3_ovf_state", fsm_state, 4);
        check("t3_ovf_flag", overflow, 1);
        check("t3_ovf_we", mem_we, 0);
        tick();
        check("t3_no_write", 32'(wr_cnt), 32'(wr_snap));
        check("t3_depth_hold", depth, 4);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t3_ack", fsm_state, 0);
        pop_op(32'h0000_300C);
        check("t3_pop_addr", mem_addr, 3);
        tick();
        tick();
        check("t3_pop_ok", fsm_state, 0);
        check("t3_depth3", depth, 3);
        for (int i = 2; i >= 0; i--) begin
            pop_op(32'h0000_3000 + 32'(4 * i));
            tick();
            tick();
            check("t3_drain_state", fsm_state, 0);
            check("t3_drain_depth", depth, 32'(i));
        end

        // Simultaneous push and pop: pop wins, push follows
        push_op(32'h0000_4000);
        tick();
        push_valid = 1'b1; push_addr  = 32'h0000_5000;
        pop_valid  = 1'b1; pop_target = 32'h0000_4000;
        #1;
        check("t5_push_rdy", push_ready, 0);
        check("t5_pop_rdy", pop_ready, 1);
        tick();
        pop_valid = 1'b0;
        check("t5_poprd", fsm_state, 2);
        tick();
        check("t5_cmp", fsm_state, 3);
        tick();
        check("t5_idle", fsm_state, 0);
        check("t5_push_rdy_back", push_ready, 1);
        tick();
        push_valid = 1'b0;
        check("t5_push", fsm_state, 1);
        check("t5_wdata", mem_wdata, 32'h0000_5000);
        tick();
        check("t5_depth", depth, 1);
        check("t5_ram0", ram[0], 32'h0000_5000);

        // Underflow with checking enabled
        pop_op(32'h0000_5000);
        tick();
        tick();
        check("t4_empty", depth, 0);
        pop_op(32'h0000_0000);
        check("t4_unf_state", fsm_state, 4);
        check("t4_unf_flag", underflow, 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;

        // Reset during POP_RD
        push_op(32'h0000_6000);
        tick();
        pop_op(32'h0000_6000);
        check("t6_poprd", fsm_state, 2);
        reset = 1'b0;
        tick();
        check("t6_state", fsm_state, 0);
        check("t6_depth", depth, 0);
        check("t6_we", mem_we, 0);
        check("t6_irq", interrupt, 0);
        check("t6_viol", stack_violation, 0);
        check("t6_ovf", overflow, 0);
        check("t6_unf", underflow, 0);
        reset = 1'b1;
        tick();

        // Underflow ignored when checking disabled
        b_pop_valid = 1'b1;
        #1;
        check("nu_pop_rdy_pre", b_pop_ready, 1);
        tick();
        check("nu_state", b_fsm_state, 0);
        check("nu_pop_rdy", b_pop_ready, 1);
        check("nu_unf", b_underflow, 0);
        check("nu_viol", b_stack_violation, 0);
        check("nu_depth", b_depth, 0);
        b_pop_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
